dm_host_ctrl: RTL and testbench

//  Host-side companion of the driver-monitor core: drives its config bus (cfg_we/cfg_addr/wght_data)
//  and services its interrupt lines (irq/irq_ack/irq_mask). After reset it streams a boot table of

---
 rtl/dm_host_ctrl.sv | 150 +++++++++++++++
 tb/tb_dm_host_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_host_ctrl.sv
// Host-side controller for the driver-monitor core: streams the boot table into the core, then
// services irq with ack/count/stuck detection and forwards host config writes.
//
//  state    | meaning
//  S_BOOT   | one boot-table write per cycle, idx 0..5
//  S_IDLE   | wait for irq (priority) or host request
//  S_ACK    | irq_ack pulse visible; cause latched and counted
//  S_WAIT_CLR | wait for irq to drop, bounded by CLR_TIMEOUT
//  S_CFG    | captured request: core write, or local irq_mask update for addr 15
module dm_host_ctrl #(
  parameter logic signed [7:0] W0          = 8'sd16,
  parameter logic signed [7:0] W1          = 8'sd16,
  parameter logic signed [7:0] W2          = 8'sd16,
  parameter logic signed [7:0] W3          = 8'sd16,
  parameter logic        [7:0] WARN_TH     = 8'd80,
  parameter logic        [7:0] EMER_TH     = 8'd160,
  parameter int                CLR_TIMEOUT = 16,
  parameter int                CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       irq,
  input  logic             req_valid,
  input  logic [3:0]       req_addr,
  input  logic [15:0]      req_data,
  output logic             req_ready,
  output logic             cfg_we,
  output logic [3:0]       cfg_addr,
  output logic [15:0]      wght_data,
  output logic             irq_ack,
  output logic [1:0]       irq_mask,
  output logic             boot_done,
  output logic [1:0]       last_cause,
  output logic [CNT_W-1:0] warn_cnt,
  output logic [CNT_W-1:0] emer_cnt,
  output logic             irq_stuck
);

  localparam int TW = $clog2(CLR_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0] BOOT_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_ACK,
    S_WAIT_CLR,
    S_CFG
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] timer;
  logic [3:0]    cap_addr;
  logic [15:0]   cap_data;

  // Weights are signed and sign-extended; thresholds are unsigned.
  function automatic logic [15:0] boot_word(input logic [2:0] i);
    logic [15:0] w;
    case (i)
      3'd0:    w = {{8{W0[7]}}, W0};
      3'd1:    w = {{8{W1[7]}}, W1};
      3'd2:    w = {{8{W2[7]}}, W2};
      3'd3:    w = {{8{W3[7]}}, W3};
      3'd4:    w = {8'h00, WARN_TH};
      3'd5:    w = {8'h00, EMER_TH};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_BOOT;
      idx        <= 3'd0;
      timer      <= '0;
      cap_addr   <= 4'd0;
      cap_data   <= 16'h0000;
      req_ready  <= 1'b0;
      cfg_we     <= 1'b0;
      cfg_addr   <= 4'd0;
      wght_data  <= 16'h0000;
      irq_ack    <= 1'b0;
      irq_mask   <= 2'b11;
      boot_done  <= 1'b0;
      last_cause <= 2'b00;
      warn_cnt   <= '0;
      emer_cnt   <= '0;
      irq_stuck  <= 1'b0;
    end else begin
      cfg_we    <= 1'b0;
      irq_ack   <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        S_BOOT: begin
          cfg_we    <= 1'b1;
          cfg_addr  <= {1'b0, idx};
          wght_data <= boot_word(idx);
          if (idx == BOOT_LAST) begin
            state <= S_IDLE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_IDLE: begin
          boot_done <= 1'b1;
          if (irq != 2'b00) begin
            state      <= S_ACK;
            irq_ack    <= 1'b1;
            last_cause <= irq;
            if (irq[0] && (warn_cnt != CNT_MAX)) warn_cnt <= warn_cnt + CNT_W'(1);
            if (irq[1] && (emer_cnt != CNT_MAX)) emer_cnt <= emer_cnt + CNT_W'(1);
          end else if (req_valid) begin
            state     <= S_CFG;
            req_ready <= 1'b1;
            cap_addr  <= req_addr;
            cap_data  <= req_data;
          end
        end
        S_ACK: begin
          timer <= '0;
          state <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (irq == 2'b00) begin
            state <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            irq_stuck <= 1'b1;
            state     <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_CFG: begin
          if (cap_addr == 4'd15) begin
            irq_mask <= cap_data[1:0];
          end else begin
            cfg_we    <= 1'b1;
            cfg_addr  <= cap_addr;
            wght_data <= cap_data;
          end
          state <= S_IDLE;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_host_ctrl.sv
// Scoreboard bench for dm_host_ctrl: expected core writes and acks are queued as stimulus is
// driven and popped by a negedge monitor when the DUT emits them.
module tb_dm_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  irq;
  logic        req_valid;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic        req_ready;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] wght_data;
  logic        irq_ack;
  logic [1:0]  irq_mask;
  logic        boot_done;
  logic [1:0]  last_cause;
  logic [15:0] warn_cnt;
  logic [15:0] emer_cnt;
  logic        irq_stuck;

  int total = 0;
  int bad   = 0;

  logic [19:0] cfg_q[$];
  logic [1:0]  ack_q[$];
  logic [15:0] warn_m = 16'd0;
  logic [15:0] emer_m = 16'd0;

  always #5 clk = ~clk;

  dm_host_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .wght_data(wght_data),
    .irq_ack(irq_ack), .irq_mask(irq_mask), .boot_done(boot_done), .last_cause(last_cause),
    .warn_cnt(warn_cnt), .emer_cnt(emer_cnt), .irq_stuck(irq_stuck)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cfg_we) begin
        if (cfg_q.size() == 0) begin
          check("cfg_unexpected", {28'd0, cfg_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [19:0] e;
          e = cfg_q.pop_front();
          check("cfg_addr", {28'd0, cfg_addr}, {28'd0, e[19:16]});
          check("cfg_data", {16'd0, wght_data}, {16'd0, e[15:0]});
        end
      end
      if (irq_ack) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", {30'd0, last_cause}, 32'hFFFF_FFFF);
        end else begin
          logic [1:0] c;
          c = ack_q.pop_front();
          check("ack_cause", {30'd0, last_cause}, {30'd0, c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_boot();
    cfg_q.push_back({4'd0, 16'h0010});
    cfg_q.push_back({4'd1, 16'h0010});
    cfg_q.push_back({4'd2, 16'h0010});
    cfg_q.push_back({4'd3, 16'h0010});
    cfg_q.push_back({4'd4, 16'h0050});
    cfg_q.push_back({4'd5, 16'h00A0});
  endtask

  task automatic check_reset_vals();
    check("rst_cfg_we", {31'd0, cfg_we}, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_irq_mask", {30'd0, irq_mask}, 32'd3);
    check("rst_warn_cnt", {16'd0, warn_cnt}, 32'd0);
    check("rst_emer_cnt", {16'd0, emer_cnt}, 32'd0);
    check("rst_stuck", {31'd0, irq_stuck}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_ack", {31'd0, irq_ack}, 32'd0);
  endtask

  // Boot runs six write cycles; the seventh edge sets boot_done and may accept a held request.
  task automatic run_boot(input logic req_held);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("boot_ready_low", {31'd0, req_ready}, 32'd0);
      check("boot_done_low", {31'd0, boot_done}, 32'd0);
    end
    cyc(1);
    check("boot_done", {31'd0, boot_done}, 32'd1);
    check("boot_ready", {31'd0, req_ready}, {31'd0, req_held});
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin cyc(1); n++; end while (!irq_ack && n < lim);
    if (!irq_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic [3:0] a, input logic [15:0] d);
    int n;
    req_valid = 1'b1; req_addr = a; req_data = d;
    n = 0;
    do begin cyc(1); n++; end while (!req_ready && n < 20);
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    cyc(1);
    req_valid = 1'b0;
    check("ready_one_cycle", {31'd0, req_ready}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; irq = 2'b00; req_valid = 1'b0; req_addr = 4'd0; req_data = 16'd0;
    cyc(3);
    check_reset_vals();

    // boot table
    push_boot();
    rst = 1'b1;
    run_boot(1'b0);
    cyc(2);
    check("boot_q_empty", cfg_q.size(), 32'd0);

    // single warning, dropped two cycles after ack
    ack_q.push_back(2'b01); warn_m = warn_m + 16'd1;
    irq = 2'b01;
    wait_ack(10, n);
    check("ack_latency", n, 32'd1);
    cyc(2);
    irq = 2'b00;
    cyc(4);
    check("warn_cnt_1", {16'd0, warn_cnt}, {16'd0, warn_m});
    check("emer_cnt_0", {16'd0, emer_cnt}, {16'd0, emer_m});
    check("last_cause_01", {30'd0, last_cause}, 32'd1);
    check("no_stuck", {31'd0, irq_stuck}, 32'd0);
    check("ack_q_empty1", ack_q.size(), 32'd0);

    // both causes held until stuck, then re-serviced
    ack_q.push_back(2'b11); ack_q.push_back(2'b11);
    irq = 2'b11;
    wait_ack(10, n);
    check("warn_after_11", {16'd0, warn_cnt}, {16'd0, warn_m + 16'd1});
    check("emer_after_11", {16'd0, emer_cnt}, {16'd0, emer_m + 16'd1});
    cyc(14);
    check("stuck_not_yet", {31'd0, irq_stuck}, 32'd0);
    wait_ack(30, n);
    irq = 2'b00;
    warn_m = warn_m + 16'd2; emer_m = emer_m + 16'd2;
    check("stuck_set", {31'd0, irq_stuck}, 32'd1);
    cyc(4);
    check("warn_after_stuck", {16'd0, warn_cnt}, {16'd0, warn_m});
    check("emer_after_stuck", {16'd0, emer_cnt}, {16'd0, emer_m});
    check("ack_q_empty2", ack_q.size(), 32'd0);

    // runtime core write
    cfg_q.push_back({4'd4, 16'h0064});
    do_req(4'd4, 16'h0064);
    cyc(3);
    check("req4_q_empty", cfg_q.size(), 32'd0);

    // forwarded high address and local mask writes
    cfg_q.push_back({4'd9, 16'hBEEF});
    do_req(4'd9, 16'hBEEF);
    do_req(4'd15, 16'h0001);
    cyc(2);
    check("mask_01", {30'd0, irq_mask}, 32'd1);
    do_req(4'd15, 16'h0003);
    cyc(2);
    check("mask_11", {30'd0, irq_mask}, 32'd3);
    check("mask_q_empty", cfg_q.size(), 32'd0);

    // irq wins over a simultaneous request; request is served afterwards
    ack_q.push_back(2'b10); emer_m = emer_m + 16'd1;
    cfg_q.push_back({4'd1, 16'hFFF0});
    irq = 2'b10; req_valid = 1'b1; req_addr = 4'd1; req_data = 16'hFFF0;
    cyc(1);
    check("prio_ack", {31'd0, irq_ack}, 32'd1);
    check("prio_ready_low", {31'd0, req_ready}, 32'd0);
    irq = 2'b00;
    do_req(4'd1, 16'hFFF0);
    cyc(3);
    check("prio_q_empty", cfg_q.size() + ack_q.size(), 32'd0);
    check("emer_prio", {16'd0, emer_cnt}, {16'd0, emer_m});

    // warning counter saturation
    @(posedge clk); #1;
    force dut.warn_cnt = 16'hFFFF;
    cyc(1);
    release dut.warn_cnt;
    cyc(1);
    check("warn_preload", {16'd0, warn_cnt}, 32'h0000_FFFF);
    ack_q.push_back(2'b01);
    irq = 2'b01;
    wait_ack(10, n);
    irq = 2'b00;
    cyc(4);
    check("warn_saturated", {16'd0, warn_cnt}, 32'h0000_FFFF);
    check("emer_unchanged", {16'd0, emer_cnt}, {16'd0, emer_m});

    // reset mid-boot with a request held across it
    rst = 1'b0;
    cyc(2);
    check_reset_vals();
    cfg_q.delete(); ack_q.delete();
    push_boot();
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    check_reset_vals();
    cfg_q.delete();
    push_boot();
    cfg_q.push_back({4'd2, 16'h1234});
    req_valid = 1'b1; req_addr = 4'd2; req_data = 16'h1234;
    rst = 1'b1;
    run_boot(1'b1);
    cyc(1);
    req_valid = 1'b0;
    check("post_ready_low", {31'd0, req_ready}, 32'd0);
    cyc(3);
    check("restart_q_empty", cfg_q.size(), 32'd0);
    check("restart_warn", {16'd0, warn_cnt}, 32'd0);
    check("restart_stuck", {31'd0, irq_stuck}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
